// File: rtl/data_sram_responder_pkg.sv
// Shared types and helpers for the CPU data-memory responder.
// Byte-lane and alignment rules live here so every user agrees.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  function automatic logic [3:0] be_n_of(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'hF;
    unique case (1'b1)
      size == SIZE_WORD: be = 4'h0;
      size == SIZE_HALF: be = a[1] ? 4'b0011 : 4'b1100;
      size == SIZE_BYTE: be = ~(4'b0001 << a);
      default:           be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    m = 1'b1;
    unique case (1'b1)
      size == SIZE_WORD: m = (a != 2'b00);
      size == SIZE_HALF: m = a[0];
      size == SIZE_BYTE: m = 1'b0;
      default:           m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU-side load/store request/ack bundle between MEM stage and responder.
// The CPU is the master, the SRAM responder is the slave.
interface data_sram_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        stall;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  ack, err, rdata, stall
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output ack, err, rdata, stall
  );
endinterface

// File: rtl/data_sram_responder_lane_align.sv
// Combinational byte-lane steering: store replication, byte enables,
// load lane extraction with sign/zero extension.
module lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] dq_i,
  output logic [3:0]  be_n,
  output logic [31:0] dq_o,
  output logic [31:0] ld_data,
  output logic        mis
);

  logic [31:0] sh;

  assign be_n = be_n_of(size, addr_lo);
  assign mis  = misaligned(size, addr_lo);
  assign sh   = dq_i >> {addr_lo, 3'b000};

  always_comb begin
    dq_o    = wdata;
    ld_data = dq_i;
    unique case (1'b1)
      size == SIZE_HALF: begin
        dq_o    = {2{wdata[15:0]}};
        ld_data = {{16{sext & sh[15]}}, sh[15:0]};
      end
      size == SIZE_BYTE: begin
        dq_o    = {4{wdata[7:0]}};
        ld_data = {{24{sext & sh[7]}}, sh[7:0]};
      end
      default: begin
        dq_o    = wdata;
        ld_data = dq_i;
      end
    endcase
  end

endmodule

// File: rtl/data_sram_responder.sv
// Data-memory responder: runs MEM-stage loads/stores against async SRAM
// with a programmable access phase; all SRAM controls are registered.
module data_sram_responder
  import mem_if_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  data_sram_responder_if.slave bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_i
);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        idle;
  logic [1:0]  sel_size;
  logic [1:0]  sel_lo;
  logic        sel_sext;
  logic [3:0]  be_n;
  logic [31:0] dq_o;
  logic [31:0] ld_data;
  logic        mis;
  logic        unused_addr;

  // In IDLE the lane logic looks at the live request; afterwards at the capture
  assign idle     = (state == IDLE);
  assign sel_size = idle ? bus.size : size_q;
  assign sel_lo   = idle ? bus.addr[1:0] : addr_lo_q;
  assign sel_sext = idle ? bus.sext : sext_q;

  assign unused_addr = ^bus.addr[31:SRAM_AW+2];

  lane_align u_lane (
    .size    (sel_size),
    .addr_lo (sel_lo),
    .sext    (sel_sext),
    .wdata   (bus.wdata),
    .dq_i    (sram_dq_i),
    .be_n    (be_n),
    .dq_o    (dq_o),
    .ld_data (ld_data),
    .mis     (mis)
  );

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.stall = bus.req & ~ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      size_q     <= SIZE_WORD;
      addr_lo_q  <= 2'b00;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            we_q      <= bus.we;
            sext_q    <= bus.sext;
            size_q    <= bus.size;
            addr_lo_q <= bus.addr[1:0];
            if (mis) begin
              state <= DONE;
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else begin
              state     <= SETUP;
              sram_ce_n <= 1'b0;
              sram_addr <= bus.addr[SRAM_AW+1:2];
              sram_be_n <= be_n;
              if (bus.we) begin
                sram_dq_oe <= 1'b1;
                sram_dq_o  <= dq_o;
              end else begin
                sram_oe_n <= 1'b0;
              end
            end
          end
        end
        SETUP: begin
          state <= ACCESS;
          cnt   <= 4'(WAIT_CYCLES - 1);
          if (we_q) sram_we_n <= 1'b0;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state     <= DONE;
            ack_q     <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!we_q) rdata_q <= ld_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // dq_oe was held through DONE for write hold time
          state      <= IDLE;
          ack_q      <= 1'b0;
          err_q      <= 1'b0;
          sram_dq_oe <= 1'b0;
          sram_be_n  <= 4'hF;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
